// File: rtl/upsample2x_stream.sv
// 2x upsampler for signed 8-bit raster rows: each pixel is emitted twice, then the row is replayed.
// Optional UPSAMPLE_ZERO_INSERT_EN selects zero-insertion upsampling instead of replication.
module upsample2x_stream #(
  parameter int IN_LENGTH = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] pixel_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] pixel_out,
  output logic              out_eol,
  output logic              out_row_odd
);

  localparam int CW = $clog2(IN_LENGTH + 1);
  localparam logic [CW-1:0] WR_END  = CW'(IN_LENGTH);
  localparam logic [CW-1:0] RD_LAST = CW'(IN_LENGTH - 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t            state;
  logic signed [7:0] hold;
  logic              hold_valid;
  logic              dup;
  logic [CW-1:0]     wr_col;
  logic [CW-1:0]     rd_col;
  logic              in_fire;
  logic              out_fire;

`ifndef UPSAMPLE_ZERO_INSERT_EN
  localparam int IW = $clog2(IN_LENGTH);
  logic signed [7:0] row_mem [IN_LENGTH];
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    pixel_out   = '0;
    out_eol     = 1'b0;
    out_row_odd = 1'b0;
    case (state)
      FILL: begin
        // A new pixel may enter while the second copy of the held one leaves.
        in_ready  = rst_n && (wr_col != WR_END) && (!hold_valid || (out_ready && dup));
        out_valid = hold_valid;
`ifdef UPSAMPLE_ZERO_INSERT_EN
        pixel_out = dup ? '0 : hold;
`else
        pixel_out = hold;
`endif
        out_eol   = (wr_col == WR_END) && dup;
      end
      REPLAY: begin
        out_valid   = 1'b1;
`ifdef UPSAMPLE_ZERO_INSERT_EN
        pixel_out   = '0;
`else
        pixel_out   = row_mem[rd_col[IW-1:0]];
`endif
        out_eol     = (rd_col == RD_LAST) && dup;
        out_row_odd = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      hold       <= '0;
      hold_valid <= 1'b0;
      dup        <= 1'b0;
      wr_col     <= '0;
      rd_col     <= '0;
`ifndef UPSAMPLE_ZERO_INSERT_EN
      row_mem    <= '{default: '0};
`endif
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            hold   <= pixel_in;
            wr_col <= wr_col + CW'(1);
`ifndef UPSAMPLE_ZERO_INSERT_EN
            row_mem[wr_col[IW-1:0]] <= pixel_in;
`endif
          end
          if (in_fire)
            hold_valid <= 1'b1;
          else if (out_fire && dup)
            hold_valid <= 1'b0;
          if (out_fire)
            dup <= !dup;
          if (out_fire && out_eol) begin
            state      <= REPLAY;
            hold_valid <= 1'b0;
            dup        <= 1'b0;
            rd_col     <= '0;
          end
        end
        REPLAY: begin
          if (out_fire) begin
            dup <= !dup;
            if (dup)
              rd_col <= rd_col + CW'(1);
            if (out_eol) begin
              state  <= FILL;
              wr_col <= '0;
              rd_col <= '0;
              dup    <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_upsample2x_stream.sv
// Directed bench for upsample2x_stream with IN_LENGTH=4; expectations follow UPSAMPLE_ZERO_INSERT_EN when defined.
module tb_upsample2x_stream;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] pixel_in;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] pixel_out;
  logic              out_eol;
  logic              out_row_odd;

  int checks = 0;
  int errors = 0;
  int odd_cycles = 0;
  int odd_ready = 0;
  logic [9:0] q[$];

  upsample2x_stream #(.IN_LENGTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixel_in   (pixel_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pixel_out  (pixel_out),
    .out_eol    (out_eol),
    .out_row_odd(out_row_odd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every output beat that the downstream side accepts.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      q.push_back({out_row_odd, out_eol, pixel_out});
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_px(input int r[4], input int b);
    int c;
    c = (b % 8) / 2;
`ifdef UPSAMPLE_ZERO_INSERT_EN
    return ((b >= 8) || (b % 2 == 1)) ? 0 : r[c];
`else
    return r[c];
`endif
  endfunction

  task automatic push(input int px);
    logic rdy;
    int n;
    n = 0;
    in_valid = 1'b1;
    pixel_in = px[7:0];
    forever begin
      @(negedge clk);
      rdy = in_ready;
      if (out_valid && out_row_odd) begin
        odd_cycles++;
        if (in_ready) odd_ready++;
      end
      @(posedge clk);
      #3;
      if (rdy) break;
      n++;
      if (n > 200) begin
        check("push_timeout", n, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int c;
    c = 0;
    while (q.size() < n && c < 2000) begin
      @(posedge clk);
      c++;
    end
    check("beat_count", q.size(), n);
  endtask

  task automatic check_row(input int r[4], input int base, input int nb);
    logic [9:0] it;
    for (int b = 0; b < nb; b++) begin
      if (base + b < q.size()) begin
        it = q[base + b];
        check($sformatf("px[%0d]", base + b), int'($signed(it[7:0])), exp_px(r, b));
        check($sformatf("eol[%0d]", base + b), int'(it[8]), (b % 8 == 7) ? 1 : 0);
        check($sformatf("odd[%0d]", base + b), int'(it[9]), (b >= 8) ? 1 : 0);
      end else begin
        check($sformatf("missing[%0d]", base + b), q.size(), base + b + 1);
      end
    end
  endtask

  int ra[4] = '{1, -2, 3, 127};
  int rb[4] = '{9, 11, 12, 13};
  int rc[4] = '{4, 5, 6, 7};
  int rd[4] = '{10, 20, 30, 40};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    pixel_in  = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_pixel_out", int'(pixel_out), 0);
    check("rst_eol", int'(out_eol), 0);
    check("rst_row_odd", int'(out_row_odd), 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Basic row at full throughput.
    for (int i = 0; i < 4; i++) push(ra[i]);
    wait_beats(16);
    check_row(ra, 0, 16);
    q.delete();

    // Backpressure on the first copy of -2.
    fork
      for (int i = 0; i < 4; i++) push(ra[i]);
      begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
          @(posedge clk);
          #2;
          if (out_valid && out_ready && pixel_out == -8'sd2 && !out_row_odd) found = 1'b1;
        end
        check("bp_found", int'(found), 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_px", int'(pixel_out), -2);
          check("bp_valid", int'(out_valid), 1);
          check("bp_eol", int'(out_eol), 0);
          check("bp_odd", int'(out_row_odd), 0);
          check("bp_in_ready", int'(in_ready), 0);
          @(posedge clk);
          #2;
        end
        out_ready = 1'b1;
      end
    join
    wait_beats(16);
    check_row(ra, 0, 16);
    q.delete();

    // Input held valid during REPLAY must stall until the next FILL row.
    for (int i = 0; i < 4; i++) push(ra[i]);
    odd_cycles = 0;
    odd_ready  = 0;
    push(rb[0]);
    check("replay_cycles", odd_cycles, 8);
    check("replay_in_ready", odd_ready, 0);
    for (int i = 1; i < 4; i++) push(rb[i]);
    wait_beats(28);
    check_row(ra, 0, 16);
    check_row(rb, 16, 2);

    // Asynchronous reset on REPLAY beat 5.
    #1;
    check("pre_rst_odd", int'(out_row_odd), 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_row_odd", int'(out_row_odd), 0);
    check("arst_pixel_out", int'(pixel_out), 0);
    check("arst_in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #3;
    q.delete();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) push(rc[i]);
    wait_beats(16);
    check_row(rc, 0, 16);
    q.delete();

    // in_valid toggling every cycle.
    begin
      int idx;
      int n;
      logic rdy;
      idx = 0;
      n = 0;
      in_valid = 1'b0;
      while (idx < 4 && n < 200) begin
        in_valid = ~in_valid;
        pixel_in = rd[idx][7:0];
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #3;
        if (in_valid && rdy) idx++;
        n++;
      end
      in_valid = 1'b0;
      check("toggle_accepted", idx, 4);
    end
    wait_beats(16);
    check_row(rd, 0, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/upsample2x_stream.md
Name: upsample2x_stream

Overview:
- 2x nearest-neighbour upsampler (unpooling) for signed 8-bit raster feature maps; the inverse of the 2x2 stride-2 max-pool stage.
- Takes one pooled row of IN_LENGTH pixels and emits two output rows of 2*IN_LENGTH pixels.
- Each pixel is duplicated horizontally, and each row is replayed from an internal row memory.
- Sits on the decoder/upsampling path, feeding conv line buffers through a valid/ready stream.

Parameters:
- IN_LENGTH, 14, pixels per input (pooled) row; output row length is 2*IN_LENGTH (28 default). Legal: IN_LENGTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  pixel_in holds a valid pixel.
- in_ready  output  1  block accepts pixel_in this cycle.
- pixel_in  input  8  signed input pixel, raster order.
- out_valid  output  1  pixel_out holds a valid pixel.
- out_ready  input  1  downstream accepts pixel_out this cycle.
- pixel_out  output  8  signed upsampled pixel.
- out_eol  output  1  pixel_out is the last column (2*IN_LENGTH-1) of an output row.
- out_row_odd  output  1  0 = first copy of the row (FILL), 1 = replayed copy (REPLAY).

Behaviour:
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State: hold (8b), hold_valid, dup (1b), wr_col, rd_col, row_mem[IN_LENGTH] of 8b.
- Reset: rst_n low clears all state asynchronously and immediately.
  - state = FILL; hold_valid = 0; dup = 0; wr_col = 0; rd_col = 0; row_mem all 0.
  - Outputs: in_ready = 0 while rst_n low; out_valid = 0, pixel_out = 0, out_eol = 0, out_row_odd = 0.
  - Reset mid-row discards the partial row; the next accepted pixel is column 0 of a new FILL row.
- FILL state:
  - in_ready = !hold_valid | (out_ready & dup), combinationally. This gives full throughput with no bubble.
  - in_ready = 0 once wr_col has reached IN_LENGTH.
  - On in_fire: hold <= pixel_in, hold_valid <= 1, row_mem[wr_col] <= pixel_in, wr_col++.
  - Latency: a pixel accepted at cycle t appears on pixel_out at t+1.
  - out_valid = hold_valid; pixel_out = hold; out_row_odd = 0.
  - On out_fire: dup toggles. If dup was 1 and there is no simultaneous in_fire, hold_valid <= 0.
  - out_eol = (wr_col == IN_LENGTH) & dup.
  - Out_fire with out_eol set moves to REPLAY: hold_valid <= 0, dup <= 0, rd_col <= 0.
- REPLAY state:
  - in_ready = 0 regardless of in_valid.
  - out_valid = 1; pixel_out = row_mem[rd_col]; out_row_odd = 1.
  - On out_fire: dup toggles; rd_col increments when dup was 1.
  - out_eol = (rd_col == IN_LENGTH-1) & dup.
  - Out_fire with out_eol set returns to FILL: wr_col <= 0, rd_col <= 0, dup <= 0.
- Backpressure: while out_valid & !out_ready, pixel_out, out_eol and out_row_odd are held stable. No pixel is dropped or duplicated beyond the 2x rule.
- Ordering: input bubbles only create output gaps. Output order is always col0,col0,col1,col1,… for the FILL row, then the identical sequence for the REPLAY row.
- Counters never wrap except at the row boundaries above. The block has no frame notion; rows repeat indefinitely.

Optional Feature:
- Macro: UPSAMPLE_ZERO_INSERT_EN
- Defined: zero-insertion upsampling (transposed-conv style).
  - The dup=0 copy in FILL emits the pixel.
  - The dup=1 copy emits 0.
  - Every REPLAY pixel emits 0.
  - row_mem and its write logic are removed; REPLAY still runs 2*IN_LENGTH beats with identical handshake and flag timing.
- Undefined: nearest-neighbour replication as described above.

Test Plan:
- IN_LENGTH=4, input [1,-2,3,127], out_ready=1 -> out = 1,1,-2,-2,3,3,127,127 (row_odd=0) then the same 8 values (row_odd=1); out_eol on beats 8 and 16 only.
- Backpressure: drop out_ready for 3 cycles while pixel_out=-2 (first copy) -> pixel_out, out_eol and out_row_odd stay stable, in_ready=0, and the sequence resumes -2,3,… with no loss.
- in_valid held 1 with pixel_in=9 throughout REPLAY -> in_ready=0 for all 8 REPLAY beats; 9 is accepted on the first FILL cycle and appears as out 9,9 first.
- Async reset asserted on REPLAY beat 5 -> out_valid=0 and out_row_odd=0 immediately; after release, row [4,5,6,7] yields 4,4,5,5,… with row_odd=0.
- in_valid toggling 1/0 every cycle with [10,20,30,40] -> out_valid has gaps; the non-gap sequence is exactly 10,10,20,20,30,30,40,40 then the replayed row.
- With UPSAMPLE_ZERO_INSERT_EN and IN_LENGTH=2, input [5,-6] -> out = 5,0,-6,0,0,0,0,0; out_eol on beats 4 and 8.
